otter_pc_sequencer: RTL and testbench

Multicycle control sequencer for the OTTER RV32I core. It steps each instruction through fetch, execute and optional writeback. It decides when the program counter loads (`PCWrite`) and which source it loads from (`pcSource`), and it enables register-file, memory and CSR writes. It sits between the instruction register and decode fields on one side and the program counter, register file, memory and CSR unit on the other.

---
 rtl/otter_pkg.sv | 24 ++
 rtl/branch_cond_gen.sv | 22 ++
 rtl/otter_pc_sequencer.sv | 113 +++++++++++
 tb/tb_otter_pc_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared opcodes, FSM states and PC mux encodings for the OTTER multicycle control path.
package otter_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {FETCH, EXEC, WB, INTR} state_t;

  localparam logic [2:0] PC_NEXT   = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

endpackage

// File: rtl/branch_cond_gen.sv
// Branch condition evaluation for the RV32I conditional branches, selected by func3.
module branch_cond_gen (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  func3,
  output logic        br_taken
);

  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = (rs1 == rs2);
      3'b001:  br_taken = (rs1 != rs2);
      3'b100:  br_taken = ($signed(rs1) <  $signed(rs2));
      3'b101:  br_taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  br_taken = (rs1 <  rs2);
      3'b111:  br_taken = (rs1 >= rs2);
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/otter_pc_sequencer.sv
// Multicycle FETCH/EXEC/WB/INTR sequencer for the OTTER core.
// Interrupt entry exists only when OTTER_INTR_EN is defined.
module otter_pc_sequencer
  import otter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        intr,
  input  logic        mie,
  output logic        PCWrite,
  output logic [2:0]  pcSource,
  output logic        regWrite,
  output logic        memRDEN1,
  output logic        memRDEN2,
  output logic        memWE2,
  output logic        csr_WE,
  output logic        int_taken,
  output logic        mret_exec
);

  state_t state, state_nxt;
  logic   br_taken;
  logic   irq_take;

  branch_cond_gen u_br (
    .rs1      (rs1),
    .rs2      (rs2),
    .func3    (func3),
    .br_taken (br_taken)
  );

`ifdef OTTER_INTR_EN
  assign irq_take = intr & mie;
`else
  logic unused_irq;
  assign unused_irq = intr ^ mie;
  assign irq_take   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = (opcode == OP_LOAD) ? WB : (irq_take ? INTR : FETCH);
      WB:      state_nxt = irq_take ? INTR : FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Reset gates every strobe so an instruction interrupted by rst writes nothing.
  always_comb begin
    PCWrite   = 1'b0;
    pcSource  = PC_NEXT;
    regWrite  = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    memWE2    = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: memRDEN1 = 1'b1;
        EXEC: begin
          PCWrite = 1'b1;
          case (opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: regWrite = 1'b1;
            OP_JAL: begin
              regWrite = 1'b1;
              pcSource = PC_JAL;
            end
            OP_JALR: begin
              regWrite = 1'b1;
              pcSource = PC_JALR;
            end
            OP_BRANCH: pcSource = br_taken ? PC_BRANCH : PC_NEXT;
            OP_STORE:  memWE2   = 1'b1;
            OP_LOAD:   memRDEN2 = 1'b1;
            OP_SYSTEM: begin
              if (func3 == 3'b000) begin
                pcSource  = PC_MEPC;
                mret_exec = 1'b1;
              end else begin
                csr_WE   = 1'b1;
                regWrite = 1'b1;
              end
            end
            default: ;
          endcase
        end
        WB: regWrite = 1'b1;
`ifdef OTTER_INTR_EN
        INTR: begin
          PCWrite   = 1'b1;
          pcSource  = PC_MTVEC;
          int_taken = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_pc_sequencer.sv
// Table-driven bench for otter_pc_sequencer with an expected-output scoreboard queue.
module tb_otter_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2;
  logic        intr, mie;
  logic        PCWrite, regWrite, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec;
  logic [2:0]  pcSource;

  int checks = 0;
  int errors = 0;

  // {PCWrite, pcSource[2:0], regWrite, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec}
  logic [10:0] sb[$];

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        irq, ie;
    logic [10:0] exp_exec;
    logic        is_load;
  } tv_t;

  tv_t vecs[$];

  otter_pc_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .rs1(rs1), .rs2(rs2),
    .intr(intr), .mie(mie), .PCWrite(PCWrite), .pcSource(pcSource), .regWrite(regWrite),
    .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .memWE2(memWE2), .csr_WE(csr_WE),
    .int_taken(int_taken), .mret_exec(mret_exec)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ov(logic pcw, logic [2:0] src, logic rw, logic r1, logic r2,
                                     logic we, logic cwe, logic it, logic mr);
    return {pcw, src, rw, r1, r2, we, cwe, it, mr};
  endfunction

  function automatic tv_t mk(string n, logic [6:0] op, logic [2:0] f3, logic [31:0] a,
                             logic [31:0] b, logic irq, logic ie, logic [10:0] e);
    tv_t t;
    t.name = n; t.op = op; t.f3 = f3; t.a = a; t.b = b; t.irq = irq; t.ie = ie;
    t.exp_exec = e; t.is_load = (op == 7'b0000011);
    return t;
  endfunction

  localparam logic [10:0] ZERO = 11'd0;

  // Push expectation, compare at the negedge, then advance to just past the next posedge.
  task automatic step(input logic [10:0] exp, input string name);
    logic [10:0] act, want;
    sb.push_back(exp);
    @(negedge clk);
    act  = {PCWrite, pcSource, regWrite, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec};
    want = sb.pop_front();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [10:0] e_fetch, e_wb, e_intr, e_alu;
    logic        take;
    e_fetch = ov(0, 0, 0, 1, 0, 0, 0, 0, 0);
    e_wb    = ov(0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_intr  = ov(1, 4, 0, 0, 0, 0, 0, 1, 0);
    e_alu   = ov(1, 0, 1, 0, 0, 0, 0, 0, 0);

    vecs.push_back(mk("addi",     7'b0010011, 3'b000, 0, 0, 0, 0, e_alu));
    vecs.push_back(mk("lui",      7'b0110111, 3'b000, 0, 0, 0, 0, e_alu));
    vecs.push_back(mk("auipc",    7'b0010111, 3'b000, 0, 0, 0, 0, e_alu));
    vecs.push_back(mk("op",       7'b0110011, 3'b000, 0, 0, 0, 0, e_alu));
    vecs.push_back(mk("jal",      7'b1101111, 3'b000, 0, 0, 0, 0, ov(1, 3, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("jalr",     7'b1100111, 3'b000, 0, 0, 0, 0, ov(1, 1, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("beq_eq",   7'b1100011, 3'b000, 32'd7, 32'd7, 0, 0, ov(1, 2, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("beq_ne",   7'b1100011, 3'b000, 32'd3, 32'd4, 0, 0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("bne",      7'b1100011, 3'b001, 32'd3, 32'd4, 0, 0, ov(1, 2, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("blt",      7'b1100011, 3'b100, 32'hFFFFFFFF, 32'd1, 0, 0, ov(1, 2, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("bltu",     7'b1100011, 3'b110, 32'hFFFFFFFF, 32'd1, 0, 0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("bge_lt",   7'b1100011, 3'b101, 32'hFFFFFFFF, 32'd1, 0, 0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("bge_eq",   7'b1100011, 3'b101, 32'd5, 32'd5, 0, 0, ov(1, 2, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("bgeu",     7'b1100011, 3'b111, 32'hFFFFFFFF, 32'd1, 0, 0, ov(1, 2, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("br_010",   7'b1100011, 3'b010, 32'd1, 32'd2, 0, 0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("br_011",   7'b1100011, 3'b011, 32'd1, 32'd2, 0, 0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("store",    7'b0100011, 3'b010, 0, 0, 0, 0, ov(1, 0, 0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk("load",     7'b0000011, 3'b010, 0, 0, 0, 0, ov(1, 0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk("mret",     7'b1110011, 3'b000, 0, 0, 0, 0, ov(1, 5, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk("csrrw",    7'b1110011, 3'b001, 0, 0, 0, 0, ov(1, 0, 1, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mk("nop_op",   7'b1111111, 3'b000, 0, 0, 0, 0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("addi_irq", 7'b0010011, 3'b000, 0, 0, 1, 1, e_alu));
    vecs.push_back(mk("addi_nie", 7'b0010011, 3'b000, 0, 0, 1, 0, e_alu));
    vecs.push_back(mk("mret_irq", 7'b1110011, 3'b000, 0, 0, 1, 1, ov(1, 5, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk("load_irq", 7'b0000011, 3'b010, 0, 0, 1, 1, ov(1, 0, 0, 0, 1, 0, 0, 0, 0)));

    rst = 1'b1; opcode = 7'd0; func3 = 3'd0; rs1 = 0; rs2 = 0; intr = 0; mie = 0;
    repeat (2) @(posedge clk);
    #1;
    step(ZERO, "reset_hold");
    rst = 1'b0;

    foreach (vecs[i]) begin
      opcode = vecs[i].op; func3 = vecs[i].f3; rs1 = vecs[i].a; rs2 = vecs[i].b;
      intr = vecs[i].irq; mie = vecs[i].ie;
`ifdef OTTER_INTR_EN
      take = vecs[i].irq & vecs[i].ie;
`else
      take = 1'b0;
`endif
      step(e_fetch, {vecs[i].name, "_fetch"});
      step(vecs[i].exp_exec, {vecs[i].name, "_exec"});
      if (vecs[i].is_load) step(e_wb, {vecs[i].name, "_wb"});
      if (take) step(e_intr, {vecs[i].name, "_intr"});
      intr = 1'b0; mie = 1'b0;
    end

    // Reset asserted mid-EXEC of a store: nothing may escape, then FETCH resumes.
    opcode = 7'b0100011; func3 = 3'b010;
    step(e_fetch, "rst_store_fetch");
    rst = 1'b1;
    step(ZERO, "rst_mid_exec");
    step(ZERO, "rst_hold2");
    rst = 1'b0;
    opcode = 7'b0010011; func3 = 3'b000;
    step(e_fetch, "rst_first_fetch");
    step(e_alu, "rst_addi_exec");
    step(e_fetch, "rst_addi_next_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
